ex: RTL and testbench

Execute stage of the 5-stage pipeline, between the decode stage (`id`) and the memory stage. Per instruction, it:
- computes the ALU result, load/store address, or branch outcome from decoded operands;
- runs multiplies on an iterative multi-cycle unit, stalling decode meanwhile;
- resolves branches and jumps back to fetch;
- latches HALT.

---
 rtl/ex_pkg.sv | 32 +++
 rtl/ex_if.sv | 37 +++
 rtl/ex_mul_iter.sv | 49 ++++
 rtl/ex.sv | 174 +++++++++++++++++
 tb/tb_ex.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared types for the execute stage: opcodes, FSM states, operand helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package ex_pkg;

  localparam int D_SIZE = 32;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,  OP_ADDI = 6'd1,  OP_SUB  = 6'd2,  OP_SUBI = 6'd3,
    OP_MUL  = 6'd4,  OP_MULI = 6'd5,  OP_OR   = 6'd6,  OP_ORI  = 6'd7,
    OP_AND  = 6'd8,  OP_ANDI = 6'd9,  OP_XOR  = 6'd10, OP_XORI = 6'd11,
    OP_LDW  = 6'd12, OP_STW  = 6'd13, OP_BZ   = 6'd14, OP_BEQ  = 6'd15,
    OP_JR   = 6'd16, OP_HALT = 6'd17
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_MUL_DONE = 2'd2,
    S_HALTED   = 2'd3
  } ex_state_e;

  // ALU pairs are laid out as (R-type, I-type) on even/odd opcodes up to xori.
  function automatic logic is_rtype(input logic [5:0] op);
    return (op <= 6'd10) && !op[0];
  endfunction

  function automatic logic is_mul(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_MULI);
  endfunction

endpackage

// File: rtl/ex_if.sv
// Bundle of decode-side inputs and memory/fetch-side outputs of the execute stage.
// Latency: n/a (wires only).
// Backpressure: stall_2_id travels back to decode inside this bundle.
interface ex_if #(parameter int D_SIZE = 32);
  logic              valid_f_id;
  logic [5:0]        opcode_f_id;
  logic [D_SIZE-1:0] rs_val_f_id;
  logic [D_SIZE-1:0] rt_val_f_id;
  logic [4:0]        dest_f_id;
  logic [D_SIZE-1:0] i_data_f_id;
  logic [31:0]       pc_f_id;

  logic              valid_2_mem;
  logic [5:0]        opcode_2_mem;
  logic [D_SIZE-1:0] result_2_mem;
  logic [D_SIZE-1:0] store_data_2_mem;
  logic [4:0]        dest_2_mem;

  logic              stall_2_id;
  logic              branch_taken_2_if;
  logic [31:0]       branch_target_2_if;
  logic              halt;

  // Execute-stage side.
  modport slave (
    input  valid_f_id, opcode_f_id, rs_val_f_id, rt_val_f_id, dest_f_id, i_data_f_id, pc_f_id,
    output valid_2_mem, opcode_2_mem, result_2_mem, store_data_2_mem, dest_2_mem,
    output stall_2_id, branch_taken_2_if, branch_target_2_if, halt
  );

  // Pipeline-environment side (decode feeding, memory/fetch consuming).
  modport master (
    output valid_f_id, opcode_f_id, rs_val_f_id, rt_val_f_id, dest_f_id, i_data_f_id, pc_f_id,
    input  valid_2_mem, opcode_2_mem, result_2_mem, store_data_2_mem, dest_2_mem,
    input  stall_2_id, branch_taken_2_if, branch_target_2_if, halt
  );
endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low D_SIZE bits kept.
// Latency: MUL_CYCLES cycles after start; done is high during the last iteration cycle.
// Backpressure: none; a new start restarts the unit and discards any run in flight.
module mul_iter #(
  parameter int D_SIZE     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [D_SIZE-1:0] i_a,
  input  logic [D_SIZE-1:0] i_b,
  output logic              o_done,
  output logic [D_SIZE-1:0] o_product
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic              r_busy;
  logic [CW-1:0]     r_cnt;
  logic [D_SIZE-1:0] r_mcand;
  logic [D_SIZE-1:0] r_mplier;
  logic [D_SIZE-1:0] r_acc;

  assign o_done    = r_busy && (r_cnt == CW'(MUL_CYCLES - 1));
  assign o_product = r_acc;

  // Latch operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) r_busy <= 1'b0;
      else        r_cnt  <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ex.sv
// Execute stage: ALU/address/branch resolution, iterative multiply, sticky halt.
// Latency: 1 cycle for non-mul; MUL_CYCLES+1 cycles after acceptance for mul.
// Backpressure: combinational stall_2_id holds decode during multiply and after halt.
module ex #(
  parameter int D_SIZE     = ex_pkg::D_SIZE,
  parameter int MUL_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  ex_if.slave  bus
);
  import ex_pkg::*;

  ex_state_e r_state, w_state_nxt;

  logic              w_vld_in, w_mul_in, w_halt_in, w_mul_start, w_mul_done;
  logic [D_SIZE-1:0] w_opb, w_mul_b, w_mul_prod;
  logic [D_SIZE-1:0] w_alu_res, w_alu_sd;
  logic [4:0]        w_alu_dest;
  logic              w_taken;
  logic [31:0]       w_target;

  logic              w_nxt_vld, w_nxt_bt, w_nxt_halt, w_stall;
  logic [5:0]        w_nxt_op;
  logic [D_SIZE-1:0] w_nxt_res, w_nxt_sd;
  logic [4:0]        w_nxt_dest;
  logic [31:0]       w_nxt_tgt;

  logic [5:0]        r_mul_op;
  logic [4:0]        r_mul_dest;

  // The cycle after a taken branch carries a wrong-path instruction, so it is a bubble.
  assign w_vld_in    = bus.valid_f_id && !bus.branch_taken_2_if && (bus.opcode_f_id <= OP_HALT);
  assign w_mul_in    = w_vld_in && is_mul(bus.opcode_f_id);
  assign w_halt_in   = w_vld_in && (bus.opcode_f_id == OP_HALT);
  assign w_mul_start = (r_state == S_IDLE) && w_mul_in;
  assign w_opb       = is_rtype(bus.opcode_f_id) ? bus.rt_val_f_id : bus.i_data_f_id;
  assign w_mul_b     = w_opb;
  assign bus.stall_2_id = w_stall;

  mul_iter #(.D_SIZE(D_SIZE), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk       (clk),
    .rst_n     (reset),
    .i_start   (w_mul_start),
    .i_a       (bus.rs_val_f_id),
    .i_b       (w_mul_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  // Single-cycle datapath: ALU result, memory address, store data and branch resolution.
  always_comb begin
    w_alu_res  = '0;
    w_alu_sd   = '0;
    w_alu_dest = bus.dest_f_id;
    w_taken    = 1'b0;
    w_target   = bus.pc_f_id + {bus.i_data_f_id[29:0], 2'b00};
    case (bus.opcode_f_id)
      OP_ADD, OP_ADDI: w_alu_res = bus.rs_val_f_id + w_opb;
      OP_SUB, OP_SUBI: w_alu_res = bus.rs_val_f_id - w_opb;
      OP_OR,  OP_ORI:  w_alu_res = bus.rs_val_f_id | w_opb;
      OP_AND, OP_ANDI: w_alu_res = bus.rs_val_f_id & w_opb;
      OP_XOR, OP_XORI: w_alu_res = bus.rs_val_f_id ^ w_opb;
      OP_LDW:          w_alu_res = bus.rs_val_f_id + bus.i_data_f_id;
      OP_STW: begin
        w_alu_res  = bus.rs_val_f_id + bus.i_data_f_id;
        w_alu_sd   = bus.rt_val_f_id;
        w_alu_dest = 5'd0;
      end
      OP_BZ: begin
        w_taken    = (bus.rs_val_f_id == '0);
        w_alu_dest = 5'd0;
      end
      OP_BEQ: begin
        w_taken    = (bus.rs_val_f_id == bus.rt_val_f_id);
        w_alu_dest = 5'd0;
      end
      OP_JR: begin
        w_taken    = 1'b1;
        w_target   = bus.rs_val_f_id[31:0];
        w_alu_dest = 5'd0;
      end
      default: w_alu_dest = 5'd0;
    endcase
  end

  // Next state, stall and next values of the output registers.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_nxt_vld   = 1'b0;
    w_nxt_op    = '0;
    w_nxt_res   = '0;
    w_nxt_sd    = '0;
    w_nxt_dest  = '0;
    w_nxt_bt    = 1'b0;
    w_nxt_tgt   = '0;
    w_nxt_halt  = bus.halt;
    case (r_state)
      S_IDLE: begin
        if (w_mul_in) begin
          w_stall     = 1'b1;
          w_state_nxt = S_MUL_BUSY;
        end else if (w_halt_in) begin
          w_nxt_vld   = 1'b1;
          w_nxt_op    = OP_HALT;
          w_nxt_halt  = 1'b1;
          w_state_nxt = S_HALTED;
        end else if (w_vld_in) begin
          w_nxt_vld  = 1'b1;
          w_nxt_op   = bus.opcode_f_id;
          w_nxt_res  = w_alu_res;
          w_nxt_sd   = w_alu_sd;
          w_nxt_dest = w_alu_dest;
          w_nxt_bt   = w_taken;
          w_nxt_tgt  = w_taken ? w_target : 32'd0;
        end
      end
      S_MUL_BUSY: begin
        w_stall = 1'b1;
        if (w_mul_done) w_state_nxt = S_MUL_DONE;
      end
      S_MUL_DONE: begin
        w_nxt_vld   = 1'b1;
        w_nxt_op    = r_mul_op;
        w_nxt_res   = w_mul_prod;
        w_nxt_dest  = r_mul_dest;
        w_state_nxt = S_IDLE;
      end
      S_HALTED: w_stall = 1'b1;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Remember which instruction the multiplier is working for.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mul_op   <= '0;
      r_mul_dest <= '0;
    end else if (w_mul_start) begin
      r_mul_op   <= bus.opcode_f_id;
      r_mul_dest <= bus.dest_f_id;
    end
  end

  // Output pipeline registers toward memory and the fetch redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.valid_2_mem        <= 1'b0;
      bus.opcode_2_mem       <= '0;
      bus.result_2_mem       <= '0;
      bus.store_data_2_mem   <= '0;
      bus.dest_2_mem         <= '0;
      bus.branch_taken_2_if  <= 1'b0;
      bus.branch_target_2_if <= '0;
      bus.halt               <= 1'b0;
    end else begin
      bus.valid_2_mem        <= w_nxt_vld;
      bus.opcode_2_mem       <= w_nxt_op;
      bus.result_2_mem       <= w_nxt_res;
      bus.store_data_2_mem   <= w_nxt_sd;
      bus.dest_2_mem         <= w_nxt_dest;
      bus.branch_taken_2_if  <= w_nxt_bt;
      bus.branch_target_2_if <= w_nxt_tgt;
      bus.halt               <= w_nxt_halt;
    end
  end
endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage with a scoreboard of expected memory-side outputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_ex;
  import ex_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  dest;
    bit          c_res;
    bit          c_sd;
    bit          c_dest;
  } exp_t;

  exp_t sb[$];
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ex_if #(.D_SIZE(32)) bus ();
  ex #(.D_SIZE(32), .MUL_CYCLES(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [5:0]  t_op  [6] = '{OP_SUB, OP_XORI, OP_AND, OP_ORI, OP_SUBI, OP_ADDI};
  logic [31:0] t_rs  [6] = '{32'd10, 32'h0000F0F0, 32'hFF00FF00, 32'h00000001, 32'd0, 32'hFFFFFFFF};
  logic [31:0] t_rt  [6] = '{32'd3, 32'hDEAD0000, 32'h0FF00FF0, 32'hDEAD0000, 32'hDEAD0000, 32'hDEAD0000};
  logic [31:0] t_imm [6] = '{32'h0000BEEF, 32'h00000FF0, 32'h0000BEEF, 32'h80000000, 32'd1, 32'd2};
  logic [31:0] t_exp [6] = '{32'd7, 32'h0000FF00, 32'h0F000F00, 32'h80000001, 32'hFFFFFFFF, 32'd1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [4:0] dest, input logic [31:0] pc);
    bus.valid_f_id  = 1'b1;
    bus.opcode_f_id = op;
    bus.rs_val_f_id = rs;
    bus.rt_val_f_id = rt;
    bus.i_data_f_id = imm;
    bus.dest_f_id   = dest;
    bus.pc_f_id     = pc;
  endtask

  task automatic bubble();
    bus.valid_f_id  = 1'b0;
    bus.opcode_f_id = '0;
    bus.rs_val_f_id = '0;
    bus.rt_val_f_id = '0;
    bus.i_data_f_id = '0;
    bus.dest_f_id   = '0;
    bus.pc_f_id     = '0;
  endtask

  task automatic expect_out(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                            input logic [4:0] dest, input bit cr, input bit cs, input bit cd);
    exp_t e;
    e.op = op; e.res = res; e.sd = sd; e.dest = dest;
    e.c_res = cr; e.c_sd = cs; e.c_dest = cd;
    sb.push_back(e);
  endtask

  // Advance one edge, then check any valid memory-side output against the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.valid_2_mem === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_vld", 32'(bus.valid_2_mem), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_op", 32'(bus.opcode_2_mem), 32'(e.op));
        if (e.c_res)  chk("sb_result", bus.result_2_mem, e.res);
        if (e.c_sd)   chk("sb_store_data", bus.store_data_2_mem, e.sd);
        if (e.c_dest) chk("sb_dest", 32'(bus.dest_2_mem), 32'(e.dest));
      end
    end
  endtask

  // Mul already on the inputs: count stall cycles, then expect the product one edge later.
  task automatic run_mul(input string tag);
    int n;
    bit dropped;
    n = 0;
    dropped = 1'b0;
    #1;
    chk({tag, "_stall_first"}, 32'(bus.stall_2_id), 32'd1);
    n = 1;
    for (int i = 0; i < 100 && !dropped; i++) begin
      tick();
      if (bus.stall_2_id === 1'b1) n++;
      else dropped = 1'b1;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
    tick();
    chk({tag, "_vld"}, 32'(bus.valid_2_mem), 32'd1);
  endtask

  initial begin
    bubble();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.valid_2_mem), 32'd0);
    chk("rst_result", bus.result_2_mem, 32'd0);
    chk("rst_halt", 32'(bus.halt), 32'd0);
    chk("rst_bt", 32'(bus.branch_taken_2_if), 32'd0);
    chk("rst_stall", 32'(bus.stall_2_id), 32'd0);
    reset = 1'b1;

    // add with wraparound
    drive(OP_ADD, 32'd7, 32'hFFFFFFFF, 32'h0000BEEF, 5'd3, 32'd0);
    expect_out(OP_ADD, 32'd6, 32'd0, 5'd3, 1, 0, 1);
    tick();
    chk("add_vld", 32'(bus.valid_2_mem), 32'd1);

    // ALU table, R-type uses rt and I-type uses imm
    for (int i = 0; i < 6; i++) begin
      drive(t_op[i], t_rs[i], t_rt[i], t_imm[i], 5'(i + 1), 32'd0);
      expect_out(t_op[i], t_exp[i], 32'd0, 5'(i + 1), 1, 0, 1);
      tick();
    end

    // load / store address and store data
    drive(OP_LDW, 32'h100, 32'h55, 32'hFFFFFFFC, 5'd2, 32'd0);
    expect_out(OP_LDW, 32'hFC, 32'd0, 5'd2, 1, 0, 1);
    tick();
    drive(OP_STW, 32'h10, 32'hAB, 32'd4, 5'd0, 32'd0);
    expect_out(OP_STW, 32'h14, 32'hAB, 5'd0, 1, 1, 0);
    tick();

    // muli with low product bits zero, then subi right after decode advances
    drive(OP_MULI, 32'h10000, 32'h777, 32'h10000, 5'd4, 32'd0);
    expect_out(OP_MULI, 32'd0, 32'd0, 5'd4, 1, 0, 1);
    run_mul("muli");
    drive(OP_SUBI, 32'd10, 32'd0, 32'd3, 5'd5, 32'd0);
    expect_out(OP_SUBI, 32'd7, 32'd0, 5'd5, 1, 0, 1);
    tick();
    chk("subi_vld", 32'(bus.valid_2_mem), 32'd1);

    // beq taken backward, following add squashed
    drive(OP_BEQ, 32'd5, 32'd5, 32'hFFFFFFFE, 5'd9, 32'h40);
    expect_out(OP_BEQ, 32'd0, 32'd0, 5'd0, 0, 0, 1);
    tick();
    chk("beq_bt", 32'(bus.branch_taken_2_if), 32'd1);
    chk("beq_tgt", bus.branch_target_2_if, 32'h38);
    drive(OP_ADD, 32'd1, 32'd1, 32'd0, 5'd7, 32'd0);
    tick();
    chk("squash_bt", 32'(bus.branch_taken_2_if), 32'd0);
    chk("squash_vld", 32'(bus.valid_2_mem), 32'd0);

    // bz not taken, then taken
    drive(OP_BZ, 32'd1, 32'd0, 32'h10, 5'd6, 32'h100);
    expect_out(OP_BZ, 32'd0, 32'd0, 5'd0, 0, 0, 1);
    tick();
    chk("bz_nt_bt", 32'(bus.branch_taken_2_if), 32'd0);
    drive(OP_BZ, 32'd0, 32'd0, 32'h10, 5'd6, 32'h100);
    expect_out(OP_BZ, 32'd0, 32'd0, 5'd0, 0, 0, 1);
    tick();
    chk("bz_t_bt", 32'(bus.branch_taken_2_if), 32'd1);
    chk("bz_t_tgt", bus.branch_target_2_if, 32'h140);

    // jr directly behind a taken branch is squashed; the next jr fires
    drive(OP_JR, 32'h200, 32'd0, 32'd0, 5'd0, 32'h80);
    tick();
    chk("jr_sq_bt", 32'(bus.branch_taken_2_if), 32'd0);
    chk("jr_sq_vld", 32'(bus.valid_2_mem), 32'd0);
    expect_out(OP_JR, 32'd0, 32'd0, 5'd0, 0, 0, 1);
    tick();
    chk("jr_bt", 32'(bus.branch_taken_2_if), 32'd1);
    chk("jr_tgt", bus.branch_target_2_if, 32'h200);

    // halt in the squash cycle is ignored
    drive(OP_HALT, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    tick();
    chk("halt_sq", 32'(bus.halt), 32'd0);
    bubble();
    #1;
    chk("halt_sq_stall", 32'(bus.stall_2_id), 32'd0);

    // real halt: sticky, later input ignored, stall held
    drive(OP_HALT, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    expect_out(OP_HALT, 32'd0, 32'd0, 5'd0, 0, 0, 0);
    tick();
    chk("halt_set", 32'(bus.halt), 32'd1);
    drive(OP_ADD, 32'd2, 32'd2, 32'd0, 5'd6, 32'd0);
    #1;
    chk("halt_stall", 32'(bus.stall_2_id), 32'd1);
    tick();
    chk("halt_add_vld", 32'(bus.valid_2_mem), 32'd0);
    tick();
    chk("halt_sticky", 32'(bus.halt), 32'd1);
    reset = 1'b0;
    #1;
    chk("halt_rst_halt", 32'(bus.halt), 32'd0);
    chk("halt_rst_op", 32'(bus.opcode_2_mem), 32'd0);
    bubble();
    #1;
    chk("halt_rst_stall", 32'(bus.stall_2_id), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // reset mid-multiply, then a fresh multiply completes normally
    drive(OP_MUL, 32'd3, 32'd5, 32'd0, 5'd9, 32'd0);
    tick();
    repeat (10) tick();
    reset = 1'b0;
    #1;
    chk("mrst_vld", 32'(bus.valid_2_mem), 32'd0);
    chk("mrst_result", bus.result_2_mem, 32'd0);
    chk("mrst_dest", 32'(bus.dest_2_mem), 32'd0);
    chk("mrst_state", 32'(dut.r_state), 32'(S_IDLE));
    bubble();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(OP_MUL, 32'h12345, 32'h1000, 32'h0000BEEF, 5'd9, 32'd0);
    expect_out(OP_MUL, 32'h12345000, 32'd0, 5'd9, 1, 0, 1);
    run_mul("mul2");
    bubble();
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
